cipher_host_ctrl: RTL and testbench
===================================

// Module: cipher_host_ctrl
// PURPOSE
//  Host-side driver for cipher_unit: takes 128-bit blocks and a 128/192/256-bit key over valid/ready
//  and sequences the unit's CLR/CK/state_i controls. Captures state_o when CF rises and returns each
//  result over valid/ready. Sits between the system datapath and one cipher_unit instance; one block in flight.
// PARAMETERS
//  CK_HOLD      2    cycles cu_ck is held high after a key load (key-expansion clear)
//  TIMEOUT_CYC  64   max RUN cycles waiting for cu_cf before abort
// PORTS
//  CLK          in   1       clock, all logic on posedge
//  CLR          in   1       synchronous active-high reset
//  key_valid    in   1       key offer
//  key_ready    out  1       key accepted when key_valid&key_ready
//  key_in       in   256     key; KEY[i]=key_in[32*i+:32]; 128/192-bit keys left-aligned from bit 255
//  key_len      in   2       0=128, 1=192, 2=256, 3=illegal
//  in_valid     in   1       block offer
//  in_ready     out  1       block accepted when in_valid&in_ready
//  in_data      in   128     block; state_i[i]=in_data[32*i+:32] (first column in [127:96])
//  in_enc_dec   in   1       1=encrypt, 0=decrypt, latched with the block
//  out_valid    out  1       result available
//  out_ready    in   1       result consumed when out_valid&out_ready
//  out_data     out  128     result, same packing as in_data
//  out_enc_dec  out  1       direction of the returned block
//  busy         out  1       FSM not in IDLE
//  err          out  1       sticky: illegal key_len or timeout; cleared only by CLR
//  blk_cnt      out  16      completed blocks, wraps 0xFFFF->0
//  cu_clr       out  1       to cipher_unit CLR
//  cu_ck        out  1       to cipher_unit CK
//  cu_key       out  32x8    to cipher_unit KEY
//  cu_kl        out  2       to cipher_unit KL
//  cu_enc_dec   out  1       to cipher_unit enc_dec
//  cu_state_i   out  32x4    to cipher_unit state_i
//  cu_state_o   in   32x4    from cipher_unit state_o
//  cu_cf        in   1       from cipher_unit CF
// BEHAVIOUR
//  Reset: FSM=IDLE, key_loaded=0, out_valid=0, err=0, blk_cnt=0, cu_clr=1, cu_ck=1.
//   All data regs=0. Reset mid-block discards the block with no output.
//  States: IDLE, KEYCLR, START, RUN, HOLD.
//  IDLE: cu_clr=1. key_ready=1.
//   in_ready = key_loaded & ~key_valid; key has priority on simultaneous offers.
//   Key handshake: latch key_in/key_len.
//    key_len=3 -> err=1, key_loaded=0, stay IDLE.
//    else key_loaded=1 -> KEYCLR.
//   Block handshake: latch in_data/in_enc_dec -> START.
//  KEYCLR: cu_ck=1 for CK_HOLD cycles, then cu_ck=0 -> IDLE. key_ready=in_ready=0.
//   cu_ck stays 0 until the next key load or reset.
//  START: one cycle with cu_clr=1 and cu_state_i/cu_enc_dec driven from the latched values -> RUN.
//  RUN: cu_clr=0, timer counts from 0.
//   cu_cf=1 sampled -> capture cu_state_o into out_data, out_enc_dec=latched direction,
//    out_valid=1, blk_cnt+1, cu_clr=1 -> HOLD.
//   timer==TIMEOUT_CYC-1 with no cu_cf -> err=1, cu_clr=1, no output, -> IDLE.
//  HOLD: out_data/out_enc_dec stable while out_valid&~out_ready.
//   Handshake -> out_valid=0 -> IDLE. No new block is accepted until then.
//  cu_key/cu_kl/cu_state_i/cu_enc_dec are registered and change only on handshakes.
//  Latency: in handshake at T -> START T+1 -> RUN from T+2 -> out_valid the cycle after cu_cf is sampled.
//  cu_cf high in a non-RUN state is ignored.
// TESTING
//  AES-128 key 000102..0f, enc pt 00112233445566778899aabbccddeeff
//   -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, blk_cnt=1.
//  AES-192 key 0001..17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191.
//  AES-256 key 0001..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089.
//   Decrypt of that ct with the same key -> original pt, out_enc_dec=0.
//  key_valid and in_valid high together in IDLE -> key taken, in_ready=0 that cycle,
//   block accepted after KEYCLR. key_len=3 -> err=1, in_ready stays 0.
//  Stub cu_cf held 0 -> err=1 exactly TIMEOUT_CYC RUN cycles after START, no out_valid.
//   out_ready=0 for 10 cycles -> out_data stable.
//  CLR asserted in RUN -> next cycle out_valid=0, busy=0, key_loaded=0, cu_clr=cu_ck=1.

Source files
------------

// File: rtl/cipher_host_ctrl.sv
// cipher_host_ctrl: host-side sequencer feeding key/blocks to one cipher_unit and returning results
module cipher_host_ctrl #(
   parameter int CK_HOLD     = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [255:0]      key_in,
   input  logic [1:0]        key_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      in_data,
   input  logic              in_enc_dec,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      out_data,
   output logic              out_enc_dec,
   output logic              busy,
   output logic              err,
   output logic [15:0]       blk_cnt,
   output logic              cu_clr,
   output logic              cu_ck,
   output logic [7:0][31:0]  cu_key,
   output logic [1:0]        cu_kl,
   output logic              cu_enc_dec,
   output logic [3:0][31:0]  cu_state_i,
   input  logic [3:0][31:0]  cu_state_o,
   input  logic              cu_cf
);
   localparam int CW = $clog2(CK_HOLD + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {IDLE, KEYCLR, START, RUN, HOLD} state_t;

   state_t            state_q;
   logic              key_loaded_q;
   logic              out_valid_q;
   logic              err_q;
   logic [15:0]       blk_cnt_q;
   logic              cu_clr_q;
   logic              cu_ck_q;
   logic [7:0][31:0]  cu_key_q;
   logic [1:0]        cu_kl_q;
   logic              cu_enc_dec_q;
   logic [3:0][31:0]  cu_state_i_q;
   logic [127:0]      out_data_q;
   logic              out_enc_dec_q;
   logic [TW-1:0]     timer_q;
   logic [CW-1:0]     ck_cnt_q;

   assign key_ready   = state_q == IDLE;
   assign in_ready    = (state_q == IDLE) & key_loaded_q & ~key_valid;
   assign busy        = state_q != IDLE;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_enc_dec = out_enc_dec_q;
   assign err         = err_q;
   assign blk_cnt     = blk_cnt_q;
   assign cu_clr      = cu_clr_q;
   assign cu_ck       = cu_ck_q;
   assign cu_key      = cu_key_q;
   assign cu_kl       = cu_kl_q;
   assign cu_enc_dec  = cu_enc_dec_q;
   assign cu_state_i  = cu_state_i_q;

   // Control FSM: key load with CK clear pulse, block start, run with timeout, result hold
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q       <= IDLE;
         key_loaded_q  <= 1'b0;
         out_valid_q   <= 1'b0;
         err_q         <= 1'b0;
         blk_cnt_q     <= '0;
         cu_clr_q      <= 1'b1;
         cu_ck_q       <= 1'b1;
         cu_key_q      <= '0;
         cu_kl_q       <= '0;
         cu_enc_dec_q  <= 1'b0;
         cu_state_i_q  <= '0;
         out_data_q    <= '0;
         out_enc_dec_q <= 1'b0;
         timer_q       <= '0;
         ck_cnt_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (key_valid) begin
                  cu_key_q <= key_in;
                  cu_kl_q  <= key_len;
                  if (key_len == 2'd3) begin
                     err_q        <= 1'b1;
                     key_loaded_q <= 1'b0;
                  end else begin
                     key_loaded_q <= 1'b1;
                     cu_ck_q      <= 1'b1;
                     ck_cnt_q     <= '0;
                     state_q      <= KEYCLR;
                  end
               end else if (in_valid && key_loaded_q) begin
                  cu_state_i_q <= in_data;
                  cu_enc_dec_q <= in_enc_dec;
                  state_q      <= START;
               end
            end
            KEYCLR: begin
               if (ck_cnt_q == CW'(CK_HOLD - 1)) begin
                  cu_ck_q <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  ck_cnt_q <= ck_cnt_q + 1'b1;
               end
            end
            START: begin
               cu_clr_q <= 1'b0;
               timer_q  <= '0;
               state_q  <= RUN;
            end
            RUN: begin
               if (cu_cf) begin
                  out_data_q    <= cu_state_o;
                  out_enc_dec_q <= cu_enc_dec_q;
                  out_valid_q   <= 1'b1;
                  blk_cnt_q     <= blk_cnt_q + 1'b1;
                  cu_clr_q      <= 1'b1;
                  state_q       <= HOLD;
               end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                  err_q    <= 1'b1;
                  cu_clr_q <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cipher_host_ctrl.sv
// tb_cipher_host_ctrl: scoreboard bench with a behavioural cipher_unit stub and random traffic
module tb_cipher_host_ctrl;
   localparam int TO = 64;
   localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   logic clr = 1'b1;
   logic key_valid = 1'b0, in_valid = 1'b0, in_enc_dec = 1'b0, out_ready = 1'b1;
   logic [255:0] key_in = '0;
   logic [1:0] key_len = '0;
   logic [127:0] in_data = '0;
   logic key_ready, in_ready, out_valid, out_enc_dec, busy, err;
   logic [127:0] out_data;
   logic [15:0] blk_cnt;
   logic cu_clr, cu_ck, cu_enc_dec, cu_cf;
   logic [7:0][31:0] cu_key;
   logic [1:0] cu_kl;
   logic [3:0][31:0] cu_state_i, cu_state_o;

   always #5 clk = ~clk;

   cipher_host_ctrl #(.CK_HOLD(2), .TIMEOUT_CYC(TO)) dut (
      .CLK(clk), .CLR(clr),
      .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in), .key_len(key_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_enc_dec(in_enc_dec),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_enc_dec(out_enc_dec),
      .busy(busy), .err(err), .blk_cnt(blk_cnt),
      .cu_clr(cu_clr), .cu_ck(cu_ck), .cu_key(cu_key), .cu_kl(cu_kl), .cu_enc_dec(cu_enc_dec),
      .cu_state_i(cu_state_i), .cu_state_o(cu_state_o), .cu_cf(cu_cf)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", n, a, e);
      end
   endtask

   // Stand-in cipher: known AES answers for the reference vectors, a keyed mix otherwise
   function automatic logic [127:0] ref_cipher(input logic [255:0] k, input logic [1:0] kl,
                                               input logic enc, input logic [127:0] pt);
      logic [127:0] m;
      if (kl == 2'd0 && enc && k == {K128, 128'h0} && pt == PT) return CT128;
      if (kl == 2'd1 && enc && k == {K192, 64'h0} && pt == PT) return CT192;
      if (kl == 2'd2 && enc && k == K256 && pt == PT) return CT256;
      if (kl == 2'd2 && !enc && k == K256 && pt == CT256) return PT;
      m = kl == 2'd0 ? 128'h0 : kl == 2'd1 ? {k[127:64], 64'h0} : k[127:0];
      return enc ? ({pt[63:0], pt[127:64]} ^ k[255:128] ^ m) : (~pt ^ k[255:128] ^ m);
   endfunction

   // cipher_unit stub: raises CF st_lat+1 cycles into RUN unless hung
   int st_cnt = 0;
   int st_lat = 3;
   bit hang = 1'b0;
   logic cf_q = 1'b0;
   logic [3:0][31:0] so_q = '0;
   assign cu_cf = cf_q;
   assign cu_state_o = so_q;
   always @(posedge clk) begin
      if (cu_clr) begin
         st_cnt <= 0;
         cf_q <= 1'b0;
      end else begin
         st_cnt <= st_cnt + 1;
         if (st_cnt == st_lat && !hang) begin
            cf_q <= 1'b1;
            so_q <= ref_cipher(cu_key, cu_kl, cu_enc_dec, cu_state_i);
         end
      end
   end

   typedef struct packed {logic [127:0] d; logic e; logic [15:0] c;} exp_t;
   exp_t q[$];
   exp_t m_e;
   logic [255:0] mkey = '0;
   logic [1:0] mkl = '0;
   logic [15:0] mcnt = '0;
   bit rdy_rand = 1'b0;

   // Monitor: pop and compare on each output handshake, check stability while stalled
   logic [127:0] prev_d;
   logic prev_e;
   bit stalled = 1'b0;
   always @(negedge clk) begin
      if (!clr && out_valid) begin
         if (stalled) begin
            chk("stall_data", out_data, prev_d);
            chk("stall_dir", out_enc_dec, prev_e);
         end
         if (out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               m_e = q.pop_front();
               chk("out_data", out_data, m_e.d);
               chk("out_dir", out_enc_dec, m_e.e);
               chk("blk_cnt", blk_cnt, m_e.c);
            end
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            prev_d = out_data;
            prev_e = out_enc_dec;
         end
      end else stalled = 1'b0;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      clr = 1'b1;
      key_valid = 1'b0;
      in_valid = 1'b0;
      hang = 1'b0;
      repeat (2) tick();
      q.delete();
      mcnt = '0;
      clr = 1'b0;
   endtask

   task automatic send_key(input logic [255:0] k, input logic [1:0] kl);
      bit ok = 1'b0;
      key_valid = 1'b1;
      key_in = k;
      key_len = kl;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (key_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("key_wait", 0, 1);
      tick();
      key_valid = 1'b0;
      if (ok && kl != 2'd3) begin mkey = k; mkl = kl; end
   endtask

   task automatic send_blk(input logic [127:0] pt, input logic enc, input int lat,
                           input bit push, input logic [127:0] exp_d, input bit chk_lat);
      bit ok = 1'b0;
      st_lat = lat;
      in_valid = 1'b1;
      in_data = pt;
      in_enc_dec = enc;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("blk_wait", 0, 1);
      tick();
      in_valid = 1'b0;
      if (ok && push) begin
         mcnt = mcnt + 16'd1;
         q.push_back({exp_d, enc, mcnt});
      end
      if (ok && chk_lat) begin
         @(negedge clk);
         chk("start_clr", cu_clr, 1);
         chk("start_state_i", cu_state_i, pt);
         chk("start_dir", cu_enc_dec, enc);
         @(negedge clk);
         chk("run_clr", cu_clr, 0);
      end
   endtask

   task automatic wait_idle;
      bit ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (!busy && !out_valid) begin ok = 1'b1; break; end
      end
      if (!ok) chk("idle_wait", 0, 1);
      tick();
   endtask

   initial begin
      int idx;
      bit sawv;
      logic [255:0] rk;
      logic [127:0] rp;
      logic re;
      do_reset();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_blk_cnt", blk_cnt, 0);
      chk("rst_cu_clr", cu_clr, 1);
      chk("rst_cu_ck", cu_ck, 1);
      chk("rst_key_ready", key_ready, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_data", out_data, 0);
      tick();
      in_valid = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("nokey_busy", busy, 0);
      tick();
      in_valid = 1'b0;

      send_key({K128, 128'h0}, 2'd0);
      @(negedge clk);
      chk("keyclr0_ck", cu_ck, 1);
      chk("keyclr0_busy", busy, 1);
      chk("keyclr0_in_ready", in_ready, 0);
      @(negedge clk);
      chk("keyclr1_ck", cu_ck, 1);
      @(negedge clk);
      chk("keyclr_done_ck", cu_ck, 0);
      chk("keyclr_done_busy", busy, 0);
      chk("key_kl", cu_kl, 0);
      tick();
      send_blk(PT, 1'b1, 4, 1'b1, CT128, 1'b1);
      wait_idle();
      chk("blk_cnt_1", blk_cnt, 1);
      send_key({K192, 64'h0}, 2'd1);
      send_blk(PT, 1'b1, 0, 1'b1, CT192, 1'b0);
      send_key(K256, 2'd2);
      send_blk(PT, 1'b1, 7, 1'b1, CT256, 1'b0);
      send_blk(CT256, 1'b0, 2, 1'b1, PT, 1'b0);
      wait_idle();

      out_ready = 1'b0;
      send_blk(PT, 1'b0, 1, 1'b1, ref_cipher(mkey, mkl, 1'b0, PT), 1'b0);
      sawv = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (out_valid) begin sawv = 1'b1; break; end
      end
      chk("stall_reached", sawv, 1);
      repeat (10) tick();
      out_ready = 1'b1;
      wait_idle();

      key_valid = 1'b1;
      key_in = {K128, 128'h0};
      key_len = 2'd0;
      in_valid = 1'b1;
      in_data = PT;
      in_enc_dec = 1'b1;
      st_lat = 5;
      @(negedge clk);
      chk("both_in_ready", in_ready, 0);
      chk("both_key_ready", key_ready, 1);
      tick();
      key_valid = 1'b0;
      mkey = {K128, 128'h0};
      mkl = 2'd0;
      idx = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (in_ready) begin idx = n; break; end
      end
      chk("both_blk_after_keyclr", idx, 2);
      tick();
      in_valid = 1'b0;
      mcnt = mcnt + 16'd1;
      q.push_back({CT128, 1'b1, mcnt});
      wait_idle();

      rdy_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send_key(rk, 2'($urandom_range(0, 2)));
         end
         rp = {$urandom, $urandom, $urandom, $urandom};
         re = 1'($urandom_range(0, 1));
         send_blk(rp, re, $urandom_range(0, 12), 1'b1, ref_cipher(mkey, mkl, re, rp), 1'b0);
      end
      wait_idle();
      rdy_rand = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("queue_drained", q.size(), 0);

      do_reset();
      send_key(K256, 2'd2);
      hang = 1'b1;
      send_blk(PT, 1'b1, 0, 1'b0, '0, 1'b0);
      idx = -1;
      sawv = 1'b0;
      for (int n = 0; n <= 100; n++) begin
         @(negedge clk);
         if (out_valid) sawv = 1'b1;
         if (err) begin idx = n; break; end
      end
      chk("timeout_cycles", idx, TO + 1);
      chk("timeout_no_out", sawv, 0);
      chk("timeout_idle", busy, 0);
      chk("timeout_clr", cu_clr, 1);
      repeat (3) tick();
      @(negedge clk);
      chk("err_sticky", err, 1);
      hang = 1'b0;
      tick();

      do_reset();
      send_key(K256, 2'd2);
      send_key(K256, 2'd3);
      @(negedge clk);
      chk("badkey_err", err, 1);
      chk("badkey_busy", busy, 0);
      tick();
      in_valid = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("badkey_in_ready", in_ready, 0);
      chk("badkey_no_start", busy, 0);
      tick();
      in_valid = 1'b0;

      do_reset();
      send_key(K256, 2'd2);
      send_blk(PT, 1'b1, 30, 1'b0, '0, 1'b0);
      repeat (3) tick();
      @(negedge clk);
      chk("pre_clr_run", cu_clr, 0);
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      @(negedge clk);
      chk("clr_out_valid", out_valid, 0);
      chk("clr_busy", busy, 0);
      chk("clr_cu_clr", cu_clr, 1);
      chk("clr_cu_ck", cu_ck, 1);
      chk("clr_key_unloaded", in_ready, 0);
      chk("clr_blk_cnt", blk_cnt, 0);
      repeat (40) tick();
      chk("clr_no_late_out", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
